// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit.
// Turns the EX/MEM memory op into a word-aligned req/ack bus transaction,
// formats load data into a registered result, and stalls the pipeline until
// the transaction has completed.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned half/word accesses
// skip the bus and raise misalign_fault while in DONE).
module mem_stage_lsu #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_en,
    input  logic                  in_mem_read,
    input  logic                  in_mem_write,
    input  logic [2:0]            in_funct3,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [DATA_WIDTH-1:0] in_store_data,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [3:0]            dmem_be,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic                  dmem_ack,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic [DATA_WIDTH-1:0] mem_read_data,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic                  misalign_fault,
`endif
    output logic                  lsu_stall
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_req;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [3:0]            r_be;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_mrd;
    logic [2:0]            r_f3;
    logic [1:0]            r_off;
    logic                  r_load;
    logic                  r_fault;

    logic                  w_op;
    logic                  w_we;
    logic [1:0]            w_off;
    logic                  w_byte;
    logic                  w_half;
    logic                  w_misalign;
    logic [3:0]            w_be;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [7:0]            w_lbyte;
    logic [15:0]           w_lhalf;
    logic [DATA_WIDTH-1:0] w_load_data;

    // Decode the incoming op into access size, byte enables and lane-replicated data
    always_comb begin
        w_op    = in_mem_read | in_mem_write;
        w_we    = in_mem_write & ~in_mem_read;
        w_off   = in_addr[1:0];
        // Loads accept the unsigned variants (1xx); stores only know 000/001
        if (in_mem_read) begin
            w_byte = (in_funct3[1:0] == 2'b00);
            w_half = (in_funct3[1:0] == 2'b01);
        end else begin
            w_byte = (in_funct3 == 3'b000);
            w_half = (in_funct3 == 3'b001);
        end
        w_misalign = (w_half & w_off[0]) | (~w_byte & ~w_half & (w_off != 2'b00));
        w_be    = 4'b1111;
        w_wdata = in_store_data;
        if (w_we && w_byte) begin
            w_be    = 4'b0001 << w_off;
            w_wdata = {4{in_store_data[7:0]}};
        end else if (w_we && w_half) begin
            w_be    = 4'b0011 << {w_off[1], 1'b0};
            w_wdata = {2{in_store_data[15:0]}};
        end
    end

    // Extract and extend the addressed lane of the returned read word
    always_comb begin
        w_lbyte = dmem_rdata[{r_off, 3'b000} +: 8];
        w_lhalf = r_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (r_f3)
            3'b000:  w_load_data = {{24{w_lbyte[7]}}, w_lbyte};
            3'b100:  w_load_data = {24'd0, w_lbyte};
            3'b001:  w_load_data = {{16{w_lhalf[15]}}, w_lhalf};
            3'b101:  w_load_data = {16'd0, w_lhalf};
            default: w_load_data = dmem_rdata;
        endcase
    end

    // Transaction FSM with registered bus outputs and load result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
            r_mrd   <= '0;
            r_f3    <= '0;
            r_off   <= '0;
            r_load  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_op) begin
                        r_we    <= w_we;
                        r_addr  <= {in_addr[ADDR_WIDTH-1:2], 2'b00};
                        r_be    <= w_be;
                        r_wdata <= w_wdata;
                        r_f3    <= in_funct3;
                        r_off   <= w_off;
                        r_load  <= in_mem_read;
`ifdef LSU_MISALIGN_TRAP_EN
                        if (w_misalign) begin
                            r_fault <= 1'b1;
                            if (in_mem_read) begin
                                r_mrd <= '0;
                            end
                            r_state <= DONE;
                        end else begin
                            r_req   <= 1'b1;
                            r_state <= REQ;
                        end
`else
                        r_req   <= 1'b1;
                        r_state <= REQ;
`endif
                    end
                end
                REQ: begin
                    if (dmem_ack) begin
                        r_req <= 1'b0;
                        if (r_load) begin
                            r_mrd <= w_load_data;
                        end
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (cpu_en) begin
                        r_fault <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Stall from the cycle the op is seen until the transaction is finished
    always_comb begin
        lsu_stall = ((r_state == IDLE) & w_op) | (r_state == REQ);
    end

    assign dmem_req      = r_req;
    assign dmem_we       = r_we;
    assign dmem_addr     = r_addr;
    assign dmem_be       = r_be;
    assign dmem_wdata    = r_wdata;
    assign mem_read_data = r_mrd;
`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_fault = r_fault;
`else
    logic w_unused;
    assign w_unused = w_misalign | r_fault;
`endif

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Load/store unit for the MEM stage; sits directly upstream of the MEM/WB pipeline register.
- Converts the EX/MEM memory op (ALU address, store data, funct3) into a word-aligned req/ack transaction on the data-memory bus.
- Formats load data (byte/half extraction, sign/zero extension) into a registered result that MEM/WB captures as its memory-read-data input.
- Stalls the pipeline until the transaction completes.

Parameters:
- DATA_WIDTH, 32, data bus and register width (fixed 32 for byte-enable logic)
- ADDR_WIDTH, 32, byte address width

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_en  in  1  global pipeline enable
- in_mem_read  in  1  current MEM-stage instruction is a load
- in_mem_write  in  1  current MEM-stage instruction is a store
- in_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- in_addr  in  ADDR_WIDTH  byte address (ALU result)
- in_store_data  in  DATA_WIDTH  rs2 value
- dmem_req  out  1  request valid, held until ack
- dmem_we  out  1  1 = write
- dmem_addr  out  ADDR_WIDTH  word address, bits [1:0] = 0
- dmem_be  out  4  byte enables
- dmem_wdata  out  DATA_WIDTH  lane-replicated store data
- dmem_ack  in  1  transaction complete; rdata valid same cycle
- dmem_rdata  in  DATA_WIDTH  read word
- mem_read_data  out  DATA_WIDTH  formatted load result, registered
- lsu_stall  out  1  combinational; pipeline enable = cpu_en & ~lsu_stall
- misalign_fault  out  1  present only with LSU_MISALIGN_TRAP_EN

Behaviour:
- Clock and reset: single clock clk; reset rst is asynchronous and active-high.
- Reset: state IDLE; dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, mem_read_data and misalign_fault all 0.
- Memory op: op = in_mem_read | in_mem_write. If both are set, the op is a read; the write is ignored.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - op=0: lsu_stall=0; remain in IDLE.
  - op=1: lsu_stall=1; register the bus outputs; dmem_req=1 next cycle; go to REQ. Leaves IDLE regardless of cpu_en.
- REQ:
  - lsu_stall=1; dmem_req, dmem_we, dmem_addr, dmem_be and dmem_wdata are held stable.
  - cpu_en is ignored: a started bus transaction always completes.
  - On dmem_ack: dmem_req=0 next cycle; for loads, the formatted rdata is registered into mem_read_data; go to DONE.
- DONE:
  - lsu_stall=0, so the pipeline advances and MEM/WB captures mem_read_data.
  - cpu_en=1: go to IDLE. cpu_en=0: stay in DONE; the same op is never reissued.
- Latency: with a zero-wait memory (ack in the first REQ cycle), one op = 3 cycles (IDLE, REQ, DONE), i.e. 2 stall cycles. Each extra wait cycle adds one stall cycle.
- dmem_ack outside REQ is ignored.
- mem_read_data:
  - Changes only on load completion.
  - Stores and non-memory cycles hold the previous value.
- Address and offset:
  - dmem_addr = {in_addr[ADDR_WIDTH-1:2], 2'b00}; off = in_addr[1:0].
- Stores:
  - SB: be = 0001<<off; wdata = {4{data[7:0]}}.
  - SH: be = 0011<<(2*off[1]); wdata = {2{data[15:0]}}.
  - SW, or any other funct3: be = 1111; wdata = data.
- Loads (be = 1111, we = 0):
  - LB/LBU: byte at lane off, sign- or zero-extended.
  - LH/LHU: half at lane off[1], sign- or zero-extended.
  - LW and undefined funct3 (011/110/111): full word.
- Reset mid-transaction: FSM goes to IDLE immediately and dmem_req drops asynchronously. The memory must tolerate an abandoned request.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - Half access with off[0]=1, or word access with off≠0, is misaligned.
  - No bus request is issued; IDLE goes directly to DONE (1 stall cycle).
  - misalign_fault=1 only while in DONE.
  - Loads write mem_read_data=0.
- Undefined:
  - No misalign_fault port.
  - Low address bits are silently ignored beyond lane selection: half uses off[1], word uses lane 0.
  - The access proceeds normally.

Test Plan:
- SW: addr=0x0000_1006 (see Optional Feature), data=0xDEADBEEF, zero-wait ack.
  - Without LSU_MISALIGN_TRAP_EN: dmem_addr=0x1004, be=1111, wdata=0xDEADBEEF, we=1; lsu_stall high exactly 2 cycles.
  - With LSU_MISALIGN_TRAP_EN: no dmem_req; misalign_fault=1 for one cycle.
- SB: addr=0x103, data=0x000000A5 -> dmem_addr=0x100, be=1000, wdata=0xA5A5A5A5.
- LB: addr=0x201, rdata=0x12348056 -> mem_read_data=0x00000080 for LBU, 0xFFFFFF80 for LB.
- LH: addr=0x302, rdata=0x9ABC0000, ack delayed 3 cycles -> dmem_req held 3 cycles with stable outputs, lsu_stall=1 for 4 cycles, mem_read_data=0xFFFF9ABC.
- DONE with cpu_en=0 for 2 cycles -> stays in DONE; no second dmem_req; then returns to IDLE.
- rst asserted during REQ -> dmem_req=0 and mem_read_data=0 immediately (before next edge), state IDLE; a following LW completes normally.
